// File: rtl/core_pkg.sv
// Shared definitions for the 24-bit core: ALU mode encodings, flag bit
// positions, default widths and the EX/MEM pipeline bundle.
package core_pkg;

  localparam int WIDTH   = 24;
  localparam int REGADDR = 4;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;
  localparam logic [2:0] ALU_SHR  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Everything the memory stage needs from one executed instruction.
  typedef struct packed {
    logic               valid;
    logic               regWe;
    logic               memWe;
    logic               writeRegFromAlu;
    logic [REGADDR-1:0] regToWrite;
    logic [WIDTH-1:0]   aluResult;
    logic [WIDTH-1:0]   dataToWrite;
    logic               branchTaken;
    logic [WIDTH-1:0]   branchTarget;
  } exMem_t;

  // Assemble a flags nibble in architectural {N,Z,C,V} order.
  function automatic logic [3:0] packFlags(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU: result and {N,Z,C,V} for one operand pair.
// Shifts use op2[4:0]; any amount at or beyond WIDTH yields zero.
module alu_unit #(
  parameter int WIDTH = core_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flagsOut
);
  import core_pkg::*;

  logic [WIDTH:0]   sumExt;
  logic             carry;
  logic             ovf;
  logic [4:0]       shamt;
  logic             shiftOut;

  assign shamt    = op2[4:0];
  assign shiftOut = (32'(shamt) >= WIDTH);

  // Operation select; logic and shift modes leave C and V clear.
  always_comb begin
    sumExt = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (mode)
      ALU_ADD: begin
        sumExt = {1'b0, op1} + {1'b0, op2};
        result = sumExt[WIDTH-1:0];
        carry  = sumExt[WIDTH];
        ovf    = (op1[WIDTH-1] == op2[WIDTH-1]) && (result[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_SUB: begin
        sumExt = {1'b0, op1} - {1'b0, op2};
        result = sumExt[WIDTH-1:0];
        // Borrow shows up in the extra bit; C is its inverse (no-borrow).
        carry  = ~sumExt[WIDTH];
        ovf    = (op1[WIDTH-1] != op2[WIDTH-1]) && (result[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_SHL:  result = shiftOut ? '0 : (op1 << shamt);
      ALU_SHR:  result = shiftOut ? '0 : (op1 >> shamt);
      ALU_PASS: result = op2;
      default:  result = op2;
    endcase
  end

  // Sign and zero come straight from the truncated result.
  always_comb begin
    flagsOut = packFlags(result[WIDTH-1], (result == '0), carry, ovf);
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 24-bit core: ALU, architectural flags register,
// jump resolution and the EX/MEM pipeline register.
//
// Flow control: validIn marks a real instruction from decode. There is no
// ready output; stall is the memory stage's backpressure and freezes the
// EX/MEM register, branch outputs and flags. flush squashes whatever would
// be loaded into a bubble and beats stall. An instruction is accepted on a
// rising edge with validIn=1, stall=0, flush=0; its results appear on the
// outputs after that edge.
module execute_stage #(
  parameter int WIDTH   = core_pkg::WIDTH,
  parameter int REGADDR = core_pkg::REGADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               validIn,
  input  logic               stall,
  input  logic               flush,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [2:0]         aluMode,
  input  logic               pcWe,
  input  logic               memWe,
  input  logic               flagsWe,
  input  logic               writeRegFromAlu,
  input  logic               regWe,
  input  logic [REGADDR-1:0] regToWrite,
  input  logic [WIDTH-1:0]   dataToWrite,
  output logic [WIDTH-1:0]   aluResult,
  output logic [WIDTH-1:0]   dataToWriteOut,
  output logic [REGADDR-1:0] regToWriteOut,
  output logic               regWeOut,
  output logic               memWeOut,
  output logic               writeRegFromAluOut,
  output logic               validOut,
  output logic               branchTaken,
  output logic [WIDTH-1:0]   branchTarget,
  output logic [3:0]         flags
);
  import core_pkg::*;

  logic [WIDTH-1:0] aluRes;
  logic [3:0]       aluFlags;
  exMem_t           exMemQ;
  logic [3:0]       flagsQ;
  logic             flagsUpdate;

  alu_unit #(
    .WIDTH (WIDTH)
  ) uAlu (
    .op1      (op1),
    .op2      (op2),
    .mode     (aluMode),
    .result   (aluRes),
    .flagsOut (aluFlags)
  );

  // Flags only move for a real, accepted instruction that asks for it.
  assign flagsUpdate = validIn & flagsWe & ~stall & ~flush;

  // EX/MEM register: flush makes a bubble, stall holds, otherwise load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exMemQ <= '0;
    end else if (flush) begin
      // Data fields are left as-is; consumers ignore them while valid is low.
      exMemQ.valid           <= 1'b0;
      exMemQ.regWe           <= 1'b0;
      exMemQ.memWe           <= 1'b0;
      exMemQ.writeRegFromAlu <= 1'b0;
      exMemQ.branchTaken     <= 1'b0;
    end else if (!stall) begin
      exMemQ.valid           <= validIn;
      exMemQ.regWe           <= regWe & validIn;
      exMemQ.memWe           <= memWe & validIn;
      exMemQ.writeRegFromAlu <= writeRegFromAlu & validIn;
      exMemQ.regToWrite      <= regToWrite;
      exMemQ.aluResult       <= aluRes;
      exMemQ.dataToWrite     <= dataToWrite;
      // A jump pulses for one accepted cycle; the next non-stalled edge
      // without a jump clears it.
      exMemQ.branchTaken     <= pcWe & validIn;
      exMemQ.branchTarget    <= op2;
    end
  end

  // Architectural flags register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flagsQ <= '0;
    end else if (flagsUpdate) begin
      flagsQ <= aluFlags;
    end
  end

  assign aluResult          = exMemQ.aluResult;
  assign dataToWriteOut     = exMemQ.dataToWrite;
  assign regToWriteOut      = exMemQ.regToWrite;
  assign regWeOut           = exMemQ.regWe;
  assign memWeOut           = exMemQ.memWe;
  assign writeRegFromAluOut = exMemQ.writeRegFromAlu;
  assign validOut           = exMemQ.valid;
  assign branchTaken        = exMemQ.branchTaken;
  assign branchTarget       = exMemQ.branchTarget;
  assign flags              = flagsQ;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases from the test plan followed by
// randomized traffic, all checked against a behavioural model through an
// expected-output queue drained by an independent monitor.
module tb_execute_stage;

  localparam int W     = 24;
  localparam int RA    = 4;
  localparam int EXP_W = 5 + RA + 3 * W + 4;
  localparam longint M = 64'd16777216;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          validIn, stall, flush;
  logic [W-1:0]  op1, op2, dataToWrite;
  logic [2:0]    aluMode;
  logic          pcWe, memWe, flagsWe, writeRegFromAlu, regWe;
  logic [RA-1:0] regToWrite;
  logic [W-1:0]  aluResult, dataToWriteOut, branchTarget;
  logic [RA-1:0] regToWriteOut;
  logic          regWeOut, memWeOut, writeRegFromAluOut, validOut, branchTaken;
  logic [3:0]    flags;

  execute_stage dut (
    .clk(clk), .reset(reset), .validIn(validIn), .stall(stall), .flush(flush),
    .op1(op1), .op2(op2), .aluMode(aluMode), .pcWe(pcWe), .memWe(memWe),
    .flagsWe(flagsWe), .writeRegFromAlu(writeRegFromAlu), .regWe(regWe),
    .regToWrite(regToWrite), .dataToWrite(dataToWrite),
    .aluResult(aluResult), .dataToWriteOut(dataToWriteOut),
    .regToWriteOut(regToWriteOut), .regWeOut(regWeOut), .memWeOut(memWeOut),
    .writeRegFromAluOut(writeRegFromAluOut), .validOut(validOut),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .flags(flags)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  monOn  = 1'b0;

  // Model of the architectural state visible at the outputs.
  bit          mValid, mRegWe, mMemWe, mWrfa, mBt;
  logic [RA-1:0] mRd;
  logic [W-1:0]  mRes, mData, mTgt;
  logic [3:0]    mFlags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkZero(input string tag);
    check({tag, " aluResult"}, 32'(aluResult), 32'd0);
    check({tag, " dataToWriteOut"}, 32'(dataToWriteOut), 32'd0);
    check({tag, " regToWriteOut"}, 32'(regToWriteOut), 32'd0);
    check({tag, " regWeOut"}, 32'(regWeOut), 32'd0);
    check({tag, " memWeOut"}, 32'(memWeOut), 32'd0);
    check({tag, " writeRegFromAluOut"}, 32'(writeRegFromAluOut), 32'd0);
    check({tag, " validOut"}, 32'(validOut), 32'd0);
    check({tag, " branchTaken"}, 32'(branchTaken), 32'd0);
    check({tag, " branchTarget"}, 32'(branchTarget), 32'd0);
    check({tag, " flags"}, 32'(flags), 32'd0);
  endtask

  // Reference ALU written with plain integer arithmetic on signed/unsigned values.
  function automatic void aluRef(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] mode,
                                 output logic [W-1:0] res, output logic [3:0] fl);
    longint ua, ub, sa, sb, u, s;
    int amt;
    bit c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= M / 2) ? ua - M : ua;
    sb = (ub >= M / 2) ? ub - M : ub;
    amt = int'(ub % 32);
    c = 1'b0;
    v = 1'b0;
    u = 0;
    case (mode)
      3'd0: begin
        u = ua + ub; c = (u >= M); s = sa + sb;
        v = (s > M / 2 - 1) || (s < -(M / 2));
      end
      3'd1: begin
        u = ua - ub + M; c = (ua >= ub); s = sa - sb;
        v = (s > M / 2 - 1) || (s < -(M / 2));
      end
      3'd2: u = longint'(a & b);
      3'd3: u = longint'(a | b);
      3'd4: u = longint'(a ^ b);
      3'd5: u = (amt >= W) ? 0 : (ua << amt);
      3'd6: u = (amt >= W) ? 0 : (ua >> amt);
      default: u = ub;
    endcase
    res = W'(u % M);
    fl  = {res[W-1], (res == '0), c, v};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit v, input bit st, input bit fl,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] mode,
                       input bit pw, input bit mw, input bit fw, input bit wra, input bit rw,
                       input logic [RA-1:0] rd, input logic [W-1:0] dat);
    logic [W-1:0] r;
    logic [3:0]   f;
    @(negedge clk);
    validIn = v; stall = st; flush = fl; op1 = a; op2 = b; aluMode = mode;
    pcWe = pw; memWe = mw; flagsWe = fw; writeRegFromAlu = wra; regWe = rw;
    regToWrite = rd; dataToWrite = dat;
    aluRef(a, b, mode, r, f);
    if (fl) begin
      mValid = 0; mRegWe = 0; mMemWe = 0; mWrfa = 0; mBt = 0;
    end else if (!st) begin
      mValid = v; mRegWe = rw & v; mMemWe = mw & v; mWrfa = wra & v; mBt = pw & v;
      mRd = rd; mRes = r; mData = dat; mTgt = b;
    end
    if (v && fw && !st && !fl) mFlags = f;
    exp_q.push_back({mValid, mRegWe, mMemWe, mWrfa, mBt, mRd, mRes, mData, mTgt, mFlags});
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 3'd0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  function automatic logic [W-1:0] pickOp();
    case ($urandom_range(0, 5))
      0: return 24'h000000;
      1: return 24'h000001;
      2: return 24'h7FFFFF;
      3: return 24'h800000;
      4: return 24'hFFFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (monOn && exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      logic eV, eRw, eMw, eWra, eBt;
      logic [RA-1:0] eRd;
      logic [W-1:0] eRes, eDat, eTgt;
      logic [3:0] eFl;
      e = exp_q.pop_front();
      {eV, eRw, eMw, eWra, eBt, eRd, eRes, eDat, eTgt, eFl} = e;
      check("validOut", 32'(validOut), 32'(eV));
      check("regWeOut", 32'(regWeOut), 32'(eRw));
      check("memWeOut", 32'(memWeOut), 32'(eMw));
      check("writeRegFromAluOut", 32'(writeRegFromAluOut), 32'(eWra));
      check("branchTaken", 32'(branchTaken), 32'(eBt));
      check("flags", 32'(flags), 32'(eFl));
      if (eV) begin
        check("aluResult", 32'(aluResult), 32'(eRes));
        check("dataToWriteOut", 32'(dataToWriteOut), 32'(eDat));
        check("regToWriteOut", 32'(regToWriteOut), 32'(eRd));
      end
      if (eBt) check("branchTarget", 32'(branchTarget), 32'(eTgt));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    validIn = 0; stall = 0; flush = 0; op1 = '0; op2 = '0; aluMode = '0;
    pcWe = 0; memWe = 0; flagsWe = 0; writeRegFromAlu = 0; regWe = 0;
    regToWrite = '0; dataToWrite = '0;
    mValid = 0; mRegWe = 0; mMemWe = 0; mWrfa = 0; mBt = 0;
    mRd = '0; mRes = '0; mData = '0; mTgt = '0; mFlags = '0;

    #2 checkZero("powerOn");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    monOn = 1'b1;

    // add r2, r0, #1
    drive(1, 0, 0, 24'd0, 24'd1, 3'b000, 0, 0, 0, 1, 1, 4'd2, 24'd0);
    // cmp 0,0 then cmp 1,2
    drive(1, 0, 0, 24'd0, 24'd0, 3'b001, 0, 0, 1, 0, 0, 4'd0, 24'd0);
    drive(1, 0, 0, 24'd1, 24'd2, 3'b001, 0, 0, 1, 0, 0, 4'd0, 24'd0);
    // signed overflow, then carry-out wrapping to zero
    drive(1, 0, 0, 24'h7FFFFF, 24'd1, 3'b000, 0, 0, 1, 1, 1, 4'd3, 24'd0);
    drive(1, 0, 0, 24'hFFFFFF, 24'd1, 3'b000, 0, 0, 1, 1, 1, 4'd4, 24'd0);
    // shifts at and beyond the width limit
    drive(1, 0, 0, 24'h00F00F, 24'd23, 3'b101, 0, 0, 1, 1, 1, 4'd5, 24'd0);
    drive(1, 0, 0, 24'hFFFFFF, 24'd24, 3'b110, 0, 0, 1, 1, 1, 4'd5, 24'd0);
    // jump #3, then a plain instruction clears branchTaken
    drive(1, 0, 0, 24'd0, 24'd3, 3'b111, 1, 0, 0, 0, 0, 4'd0, 24'd0);
    drive(1, 0, 0, 24'd5, 24'd6, 3'b000, 0, 0, 0, 1, 1, 4'd1, 24'd0);
    // jump held across a stall, then cleared
    drive(1, 0, 0, 24'd0, 24'h000ABC, 3'b111, 1, 0, 0, 0, 0, 4'd0, 24'd0);
    drive(1, 1, 0, 24'd9, 24'd7, 3'b000, 1, 0, 1, 1, 1, 4'd6, 24'd0);
    idle();
    // store accepted, two stalled cycles with changing inputs, then flush+stall
    drive(1, 0, 0, 24'd0, 24'd3, 3'b111, 0, 1, 0, 0, 0, 4'd0, 24'h000055);
    drive(1, 1, 0, 24'h123456, 24'h000777, 3'b000, 0, 0, 1, 1, 1, 4'd7, 24'd1);
    drive(1, 1, 0, 24'h654321, 24'h000888, 3'b001, 1, 0, 1, 1, 1, 4'd8, 24'd2);
    drive(1, 1, 1, 24'h000001, 24'h000001, 3'b001, 1, 1, 1, 1, 1, 4'd9, 24'd3);
    // validIn low with every control high: nothing propagates
    drive(0, 0, 0, 24'd1, 24'd2, 3'b001, 1, 1, 1, 1, 1, 4'hF, 24'd4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
            pickOp(), pickOp(), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), W'($urandom));
    end

    // leave nonzero state behind for the asynchronous reset check
    drive(1, 0, 0, 24'd1, 24'd2, 3'b001, 1, 1, 1, 1, 1, 4'd7, 24'h00BEEF);
    begin
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
        @(posedge clk);
        #2;
        n++;
      end
    end
    check("queueDrained", 32'(exp_q.size()), 32'd0);
    monOn = 1'b0;

    // assert reset away from any clock edge
    @(posedge clk);
    #3 reset = 1'b0;
    #1 checkZero("asyncReset");
    validIn = 0; stall = 0; flush = 0; pcWe = 0; memWe = 0; flagsWe = 0;
    writeRegFromAlu = 0; regWe = 0; op1 = '0; op2 = '0; dataToWrite = '0; regToWrite = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2 checkZero("postRelease");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Third pipeline stage of the 24-bit core. Sits directly downstream of the decode stage.
- Consumes the decoded operands and control bits: op1, op2, aluMode, pcWe, memWe, flagsWe, writeRegFromAlu, regWe, regToWrite, dataToWrite.
- Computes the ALU result and maintains the architectural flags register.
- Resolves unconditional jumps and registers everything into the EX/MEM pipeline register for the memory stage.

Parameters:
- WIDTH, 24, datapath width of operands, result and PC target.
- REGADDR, 4, register-index width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (port name per codebase; low = reset asserted).
- validIn  in  1  decode output holds a real instruction.
- stall  in  1  memory stage not ready; hold EX/MEM register and flags.
- flush  in  1  hazard unit squash; load a bubble.
- op1  in  WIDTH  first operand.
- op2  in  WIDTH  second operand / immediate / jump target.
- aluMode  in  3  ALU operation select.
- pcWe, memWe, flagsWe, writeRegFromAlu, regWe  in  1 each  decoded controls.
- regToWrite  in  REGADDR  destination register.
- dataToWrite  in  WIDTH  store data.
- aluResult  out  WIDTH  registered ALU result.
- dataToWriteOut  out  WIDTH  registered store data.
- regToWriteOut  out  REGADDR  registered destination.
- regWeOut, memWeOut, writeRegFromAluOut, validOut  out  1 each  registered controls.
- branchTaken  out  1  registered; jump resolved last cycle.
- branchTarget  out  WIDTH  registered jump target (= op2).
- flags  out  4  architectural {N,Z,C,V}.

Behaviour:
- Reset (reset=0, asynchronous): all outputs and the flags register go to 0 immediately and stay 0 until the first rising edge after release.
- ALU is combinational; one-cycle latency to the registered outputs.
- ALU modes:
  - 000 add: op1+op2, C = carry-out, V = signed overflow.
  - 001 sub/cmp: op1-op2, C = no-borrow (op1>=op2 unsigned), V = signed overflow.
  - 010 and; 011 or; 100 xor.
  - 101 shl by op2[4:0]; 110 shr logical by op2[4:0]. Shift amounts >= 24 give 0.
  - 111 pass op2.
  - Logic and shift modes set C=0, V=0.
  - N = result[23]; Z = (result==0).
- Result is truncated to WIDTH; no saturation.
- Flags register updates only when validIn & flagsWe & !stall & !flush. Otherwise it holds.
- Edge priority, highest first:
  - flush: EX/MEM loads a bubble (validOut=0, regWeOut=memWeOut=writeRegFromAluOut=0, branchTaken=0). Data fields may hold any value; verify ignores them when validOut=0. flush overrides stall.
  - stall: all EX/MEM outputs, branchTaken/branchTarget and flags hold their values.
  - else: register ALU result and the pass-through fields. Each control out = control in & validIn. validOut = validIn.
- Jump: when validIn & pcWe is accepted, on the next cycle branchTaken=1 and branchTarget=op2 for exactly one cycle, unless a stall holds it.
  - branchTaken is not re-asserted by a held stage: while stalled it keeps its value, and it clears on the first non-stalled edge with no new jump.
- Back-to-back instructions with no stall: one per cycle, no bubbles inserted by this block.
- validIn=0 with nonzero controls: no write enables propagate and flags do not change.
- Reset during a stall or flush: the asynchronous clear wins.

Decomposition:
- Shared package core_pkg holds:
  - ALU mode constants (ALU_ADD=3'b000 ... ALU_PASS=3'b111).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - WIDTH/REGADDR defaults.
  - A packed struct for the EX/MEM bundle.
- One combinational sub-module, alu_unit: op1, op2, mode -> result, {N,Z,C,V}.
- Pipeline register, flags register and jump logic stay in execute_stage.

Test Plan:
- Reset: drive reset=0 mid-cycle with prior nonzero state -> all outputs 0 immediately. After release and the first edge with validIn=0 -> outputs still 0.
- add r2, r0, #1: op1=0, op2=1, aluMode=000, regWe=1, writeRegFromAlu=1, regToWrite=2 -> next cycle aluResult=1, regWeOut=1, regToWriteOut=2, flags unchanged (flagsWe=0).
- cmp: op1=0, op2=0, aluMode=001, flagsWe=1 -> flags=4'b0110 (Z=1, C=1). Then op1=1, op2=2 -> aluResult=24'hFFFFFF, flags=4'b1000.
- add overflow: op1=24'h7FFFFF, op2=1, flagsWe=1 -> aluResult=24'h800000, flags N=1, V=1, C=0. Then op1=24'hFFFFFF, op2=1 -> aluResult=0, Z=1, C=1.
- Jump #3: pcWe=1, op2=3 -> next cycle branchTaken=1, branchTarget=3. The following cycle with no jump -> branchTaken=0.
- Stall then flush: store with memWe=1, op2=3 accepted, then stall=1 for 2 cycles while inputs change -> outputs hold memWeOut=1, aluResult=3. Then flush=1 with stall=1 -> validOut=0, memWeOut=0, flags unchanged.
